// File: rtl/dyser_input_queue.sv
// Dual-lane CPU-to-fabric input queue: one circular FIFO per fabric port,
// all-or-nothing enqueue of up to two lanes per cycle, per-port pop, commit flush.
module dyser_input_queue #(
   parameter  int DATA_W = 64,
   parameter  int NPORTS = 8,
   parameter  int DEPTH  = 4,
   localparam int PW     = $clog2(NPORTS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     send_en0,
   input  logic                     send_en1,
   input  logic [PW-1:0]            send_port_r0,
   input  logic [PW-1:0]            send_port_r1,
   input  logic [DATA_W-1:0]        send_data_r0,
   input  logic [DATA_W-1:0]        send_data_r1,
   output logic                     send_stall,
   input  logic                     commit,
   output logic [NPORTS-1:0]        out_valid,
   output logic [NPORTS*DATA_W-1:0] out_data,
   input  logic [NPORTS-1:0]        out_ready,
   output logic                     all_empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [DATA_W-1:0] r_mem [NPORTS][DEPTH];
   logic [CW-1:0]     r_cnt [NPORTS];
   logic [AW-1:0]     r_wr  [NPORTS];
   logic [AW-1:0]     r_rd  [NPORTS];

   logic [1:0]        w_need    [NPORTS];
   logic [1:0]        w_push    [NPORTS];
   logic [CW-1:0]     w_cnt_nxt [NPORTS];
   logic [AW-1:0]     w_wr_nxt  [NPORTS];
   logic [AW-1:0]     w_rd_nxt  [NPORTS];
   logic [NPORTS-1:0] w_over;
   logic [NPORTS-1:0] w_pop;
   logic              w_stall;
   logic              w_acc0;
   logic              w_acc1;
   logic              w_same;

   // Space check uses the registered count only; a same-cycle pop earns no credit.
   always_comb begin
      w_over = '0;
      w_pop  = '0;
      for (int p = 0; p < NPORTS; p++) begin
         w_need[p] = {1'b0, send_en0 && (send_port_r0 == PW'(p))}
                   + {1'b0, send_en1 && (send_port_r1 == PW'(p))};
         w_over[p] = CW'(w_need[p]) > (CW'(DEPTH) - r_cnt[p]);
         w_pop[p]  = out_valid[p] & out_ready[p];
      end
   end

   assign w_stall    = rst | commit | (|w_over);
   assign send_stall = w_stall;
   assign w_acc0     = send_en0 & ~w_stall;
   assign w_acc1     = send_en1 & ~w_stall;
   assign w_same     = send_en0 && (send_port_r0 == send_port_r1);

   always_comb begin
      for (int p = 0; p < NPORTS; p++) begin
         w_push[p]    = w_stall ? 2'd0 : w_need[p];
         w_cnt_nxt[p] = r_cnt[p] + CW'(w_push[p]) - CW'(w_pop[p]);
         w_wr_nxt[p]  = r_wr[p] + AW'(w_push[p]);
         w_rd_nxt[p]  = r_rd[p] + AW'(w_pop[p]);
      end
   end

   always_ff @(posedge clk) begin
      for (int p = 0; p < NPORTS; p++) begin
         if (rst || commit) begin
            r_cnt[p] <= '0;
            r_wr[p]  <= '0;
            r_rd[p]  <= '0;
         end else begin
            r_cnt[p] <= w_cnt_nxt[p];
            r_wr[p]  <= w_wr_nxt[p];
            r_rd[p]  <= w_rd_nxt[p];
         end
      end
   end

   // Storage is not reset; lane 1 lands one slot after lane 0 when they share a port.
   always_ff @(posedge clk) begin
      for (int p = 0; p < NPORTS; p++) begin
         if (w_acc0 && (send_port_r0 == PW'(p)))
            r_mem[p][r_wr[p]] <= send_data_r0;
         if (w_acc1 && (send_port_r1 == PW'(p)))
            r_mem[p][w_same ? r_wr[p] + AW'(1) : r_wr[p]] <= send_data_r1;
      end
   end

   always_comb begin
      out_valid = '0;
      out_data  = '0;
      for (int p = 0; p < NPORTS; p++) begin
         out_valid[p] = (r_cnt[p] != '0);
         if (r_cnt[p] != '0)
            out_data[p*DATA_W +: DATA_W] = r_mem[p][r_rd[p]];
      end
   end

   assign all_empty = ~|out_valid;

endmodule

// File: doc/dyser_input_queue.md
DYSER_INPUT_QUEUE -- requirements
Module: dyser_input_queue

Interface
REQ-001 SHALL have parameter DATA_W, default 64, meaning the payload width per lane and per port.
REQ-002 SHALL have parameter NPORTS, default 8, meaning the number of fabric input ports; legal values are 2..16.
REQ-003 SHALL have parameter DEPTH, default 4, meaning the entries per port FIFO; legal values are powers of two, 2..16.
REQ-004 SHALL have derived localparam PW = clog2(NPORTS), meaning the port index width.
REQ-005 SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit, meaning the synchronous, active-high reset.
REQ-007 SHALL have port send_en0 / send_en1, input, 1 bit each, meaning the lane-0/lane-1 enqueue request.
REQ-008 SHALL have port send_port_r0 / send_port_r1, input, PW bits each, meaning the target port per lane.
REQ-009 SHALL have port send_data_r0 / send_data_r1, input, DATA_W bits each, meaning the payload per lane.
REQ-010 SHALL have port send_stall, output, 1 bit, meaning the CPU-side hold (combinational).
REQ-011 SHALL have port commit, input, 1 bit, meaning flush all ports.
REQ-012 SHALL have port out_valid, output, NPORTS bits, meaning per-port head valid.
REQ-013 SHALL have port out_data, output, NPORTS*DATA_W bits, meaning per-port head data; port p occupies bits [p*DATA_W +: DATA_W].
REQ-014 SHALL have port out_ready, input, NPORTS bits, meaning the per-port fabric pop.
REQ-015 SHALL have port all_empty, output, 1 bit, meaning every port count is 0.

Function
REQ-016 SHALL keep one circular FIFO per port with wr_ptr, rd_ptr and count (0..DEPTH); pointers wrap DEPTH-1 -> 0.
REQ-017 SHALL compute the free-slot need per port as the number of enabled lanes targeting it (0, 1 or 2) and the free space as DEPTH - count, using the registered count only (no credit for a same-cycle pop).
REQ-018 SHALL assert send_stall if any port's need exceeds its free space, if commit=1, or if rst=1.
REQ-019 SHALL make enqueue all-or-nothing: when send_stall=1 neither lane writes, and when send_stall=0 every enabled lane writes.
REQ-020 SHALL, when both lanes target the same port, write lane 0 at wr_ptr and lane 1 at wr_ptr+1 (mod DEPTH), advancing wr_ptr by 2.
REQ-021 SHALL drive out_valid[p] = (count[p] != 0) and out_data[p] = entry at rd_ptr[p], both from registered state only.
REQ-022 SHALL pop port p when out_valid[p] & out_ready[p]; out_ready on an empty port is ignored.
REQ-023 SHALL set latency to 1 cycle: data written at edge N is visible on out_valid/out_data after edge N; there is no same-cycle bypass.
REQ-024 SHALL, on simultaneous push and pop on one port, apply both: count += pushes - pop.
REQ-025 SHALL have commit take effect at the next edge: all counts and pointers go to 0, sends are suppressed, and pops that cycle are discarded.
REQ-026 SHALL give commit and rst priority over push and pop; rst has priority over commit.
REQ-027 SHALL drive all_empty = 1 when all counts are 0.
REQ-028 SHALL keep every count within 0..DEPTH under all legal stimulus, with no overflow or underflow; the bench asserts this.

Reset
REQ-029 SHALL, while rst=1 at a rising edge, clear all counts, wr_ptr and rd_ptr to 0.
REQ-030 SHALL hold the following values during and after reset: out_valid = 0, all_empty = 1, and send_stall = 1 while rst is high, then 0 after rst is released.
REQ-031 SHALL leave FIFO storage contents undefined after reset and never expose them while count is 0.
REQ-032 SHALL, when reset occurs mid-operation, discard all queued data; the first cycle after reset behaves as an empty queue.

Verification (DATA_W=64, NPORTS=8, DEPTH=4)
REQ-033 SHALL cover dual-lane send to distinct ports: send P4=0x0 and P3=0x1 in one cycle -> next cycle out_valid=8'h18, out_data[4]=0x0, out_data[3]=0x1, send_stall=0.
REQ-034 SHALL cover same-port ordering: send P2=0x55 and P2=0xff in one cycle, then pop P2 twice -> pops return 0x55 then 0xff, followed by out_valid[2]=0.
REQ-035 SHALL cover full/stall: 2 dual sends to P6 (4 entries), then a third send to P6 -> send_stall=1 and no write; one pop -> single-lane send accepted while a dual send to P6 still stalls.
REQ-036 SHALL cover wrap-around: 10 single sends of 0x1..0xA to P0, each popped when 2 are queued -> output sequence is exactly 0x1..0xA.
REQ-037 SHALL cover commit flush: queue 3 entries on P5 and 1 on P7, then commit=1 with send_en0 on P1 -> send_stall=1 that cycle, next cycle all_empty=1 and out_valid=0, with no P1 write.
REQ-038 SHALL cover mid-operation reset: with P1 full, assert rst one cycle while sending -> send_stall=1, then out_valid=0 and all_empty=1, and a fresh send to P1 is accepted.
